// File: rtl/four_phase_sink.sv
// four_phase_sink
// Clocked consumer end of a four-phase bundled-data handshake. The request is
// brought into the clock domain through a synchronizer chain. Each accepted
// token is written into a small show-ahead FIFO, and the FIFO contents are
// presented downstream as a valid/ready stream. The acknowledge is a dedicated
// flop, so the pipeline never sees a combinational glitch on it.

module four_phase_sink #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hs_req,
  input  logic [DATA_W-1:0]          hs_data,
  output logic                       hs_ack,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                xfer_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  // ------------------------------------------------------------------
  // Request synchronizer
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   req_sync_s;

  // Shift the asynchronous request through the synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], hs_req};
    end
  end

  assign req_sync_s = sync_r[SYNC_STAGES-1];

  // ------------------------------------------------------------------
  // FIFO status, derived from the registered occupancy
  // ------------------------------------------------------------------
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_next_s;
  logic [CW-1:0]     wr_ptr_r;
  logic [CW-1:0]     wr_ptr_next_s;
  logic [CW-1:0]     rd_ptr_r;
  logic [CW-1:0]     rd_ptr_next_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  // Full is judged on the current occupancy only, so a same-cycle pop
  // cannot open room for a push while full.
  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == CW'(1'b0));
  assign pop_s   = (!empty_s) && m_ready;

  // ------------------------------------------------------------------
  // Handshake FSM (state register / next state / outputs)
  // ------------------------------------------------------------------
  state_t state_r;
  state_t state_next_s;
  logic   ack_r;
  logic   ack_next_s;

  // State register for the handshake controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: accept a token only when there is room; hold in ACK
  // until the synchronized request returns to zero
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_sync_s && !full_s) begin
          state_next_s = ST_ACK;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!req_sync_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ACK;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output logic: a push happens only on the IDLE->ACK transition; the next
  // acknowledge level follows the next state
  always_comb begin
    push_s     = 1'b0;
    ack_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_sync_s && !full_s) begin
          push_s     = 1'b1;
          ack_next_s = 1'b1;
        end else begin
          push_s     = 1'b0;
          ack_next_s = 1'b0;
        end
      end
      ST_ACK: begin
        push_s = 1'b0;
        if (req_sync_s) begin
          ack_next_s = 1'b1;
        end else begin
          ack_next_s = 1'b0;
        end
      end
      default: begin
        push_s     = 1'b0;
        ack_next_s = 1'b0;
      end
    endcase
  end

  // Acknowledge flop: the pipeline sees only this register, never logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= 1'b0;
    end else begin
      ack_r <= ack_next_s;
    end
  end

  // ------------------------------------------------------------------
  // FIFO datapath
  // ------------------------------------------------------------------

  // Occupancy and pointer updates; pointers carry a wrap bit and advance
  // modulo DEPTH through natural overflow of the index bits
  always_comb begin
    count_next_s  = count_r;
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    case ({push_s, pop_s})
      2'b10: begin
        count_next_s = count_r + CW'(1'b1);
      end
      2'b01: begin
        count_next_s = count_r - CW'(1'b1);
      end
      default: begin
        count_next_s = count_r;
      end
    endcase
    if (push_s) begin
      wr_ptr_next_s = wr_ptr_r + CW'(1'b1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + CW'(1'b1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      count_r  <= count_next_s;
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
    end
  end

  // Storage array; hs_data is sampled directly, relying on the bundled-data
  // guarantee that it is stable once the request has been synchronized
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= hs_data;
      end
    end
  end

  // ------------------------------------------------------------------
  // Registered stream head
  // ------------------------------------------------------------------
  logic              m_valid_r;
  logic [DATA_W-1:0] m_data_r;
  logic [DATA_W-1:0] head_next_s;

  // Next head word. When the FIFO will hold exactly one entry and that entry
  // is being written this cycle, it has not reached the array yet, so it is
  // forwarded from hs_data. An empty FIFO keeps showing the last word.
  always_comb begin
    head_next_s = m_data_r;
    if (count_next_s == CW'(1'b0)) begin
      head_next_s = m_data_r;
    end else if (push_s && (count_next_s == CW'(1'b1))) begin
      head_next_s = hs_data;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s[AW-1:0]];
    end
  end

  // Stream valid/data registers, kept in step with the occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
    end else begin
      m_valid_r <= (count_next_s != CW'(1'b0));
      m_data_r  <= head_next_s;
    end
  end

  // ------------------------------------------------------------------
  // Accepted-token counter
  // ------------------------------------------------------------------
  logic [15:0] xfer_cnt_r;
  logic [15:0] xfer_next_s;

  // Counter increment on every accepted token; wraps silently
  always_comb begin
    xfer_next_s = xfer_cnt_r;
    if (push_s) begin
      xfer_next_s = xfer_cnt_r + 16'd1;
    end else begin
      xfer_next_s = xfer_cnt_r;
    end
  end

  // Accepted-token counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_r <= 16'd0;
    end else begin
      xfer_cnt_r <= xfer_next_s;
    end
  end

  // ------------------------------------------------------------------
  // Outputs, all driven from flops
  // ------------------------------------------------------------------
  assign hs_ack     = ack_r;
  assign m_valid    = m_valid_r;
  assign m_data     = m_data_r;
  assign fifo_count = count_r;
  assign xfer_count = xfer_cnt_r;

endmodule
